// File: rtl/block_ram_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port block RAM.
package block_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int NUM_LANES(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit lanes_fit(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/block_ram_clear_ctrl.sv
// Zero-fill sequencer: sweeps every word after reset, then hands the write port to port A.
module block_ram_clear_ctrl
    import block_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rsta,
    output logic                  init_busy,
    output logic                  clr_sel,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0] clr_data
);

    // One extra counter bit so the final address never aliases back to zero.
    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_WIDTH:0] cnt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
                state_nxt = READY;
            end
        end
    end

    always_comb begin
        init_busy = (state == CLEAR);
        clr_sel   = (state == CLEAR);
        clr_addr  = cnt[ADDR_WIDTH-1:0];
        clr_data  = '0;
    end

endmodule

// File: rtl/block_ram_sdp.sv
// Simple-dual-port block RAM with byte-lane writes, registered read and post-reset zero fill.
// Define BRAM_BYPASS_EN for write-first collisions; the default build is read-first.
module block_ram_sdp
    import block_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                          clka,
    input  logic                                          rsta,
    input  logic [ADDR_WIDTH-1:0]                         addra,
    input  logic [DATA_WIDTH-1:0]                         dina,
    input  logic [NUM_LANES(DATA_WIDTH, BYTE_WIDTH)-1:0] wea,
    input  logic                                          enb,
    input  logic [ADDR_WIDTH-1:0]                         addrb,
    output logic [DATA_WIDTH-1:0]                         doutb,
    output logic                                          validb,
    output logic                                          init_busy
);

    localparam int LANES = NUM_LANES(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!lanes_fit(DATA_WIDTH, BYTE_WIDTH)) begin : g_width_check
        $error("block_ram_sdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_sel;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      wr_lane_en;
    logic [LANES-1:0]      byp_lane;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout_p1;
    logic                  vld_p1;

    block_ram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clear_ctrl (
        .clka      (clka),
        .rsta      (rsta),
        .init_busy (init_busy),
        .clr_sel   (clr_sel),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data)
    );

    // Single write port shared by the sweep and port A; edges seen under reset write nothing.
    always_comb begin
        wr_addr    = addra;
        wr_data    = dina;
        wr_lane_en = wea;
        if (clr_sel) begin
            wr_addr    = clr_addr;
            wr_data    = clr_data;
            wr_lane_en = '1;
        end
        if (rsta) begin
            wr_lane_en = '0;
        end
    end

    assign rd_en = enb && !clr_sel;

`ifdef BRAM_BYPASS_EN
    assign byp_lane = (!clr_sel && (addra == addrb)) ? wea : '0;
`else
    assign byp_lane = '0;
`endif

    always_ff @(posedge clka) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_en[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Stage p1: array read register with the per-lane bypass mux folded in front of it.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                for (int i = 0; i < LANES; i++) begin
                    dout_p1[i*BYTE_WIDTH +: BYTE_WIDTH] <= byp_lane[i]
                        ? dina[i*BYTE_WIDTH +: BYTE_WIDTH]
                        : mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign doutb  = dout_p1;
    assign validb = vld_p1;

endmodule

// File: tb/tb_block_ram_sdp.sv
// Directed self-checking bench for block_ram_sdp (16 words x 32 bits, byte lanes).
module tb_block_ram_sdp;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 8;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina = '0;
    logic [3:0]    wea = '0;
    logic          enb = 1'b0;
    logic [AW-1:0] addrb = '0;
    logic [DW-1:0] doutb;
    logic          validb;
    logic          init_busy;

    int checks   = 0;
    int failures = 0;

    block_ram_sdp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (BW)
    ) dut (
        .clka      (clka),
        .rsta      (rsta),
        .addra     (addra),
        .dina      (dina),
        .wea       (wea),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .validb    (validb),
        .init_busy (init_busy)
    );

    always #5 clka = ~clka;

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] we);
        addra = a;
        dina  = d;
        wea   = we;
        @(posedge clka);
        #1;
        wea = '0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] q, output logic v);
        enb   = 1'b1;
        addrb = a;
        @(posedge clka);
        #1;
        enb = 1'b0;
        q   = doutb;
        v   = validb;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clka);
            #1;
            n++;
            if (!init_busy) break;
        end
    endtask

    task automatic test_reset;
        rsta = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        dut.mem[5] = 32'hFFFF_FFFF;
        checks++;
        if (doutb !== 32'h0) begin
            failures++;
            $display("FAIL reset_doutb got=%h want=%h", doutb, 32'h0);
        end
        checks++;
        if (validb !== 1'b0) begin
            failures++;
            $display("FAIL reset_validb got=%b want=0", validb);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got=%b want=1", init_busy);
        end
    endtask

    task automatic test_blocked_sweep;
        int n;
        int vseen;
        logic [DW-1:0] q;
        logic v;
        addra = 4'd2;
        dina  = 32'h5A5A_5A5A;
        wea   = 4'hF;
        enb   = 1'b1;
        addrb = 4'd2;
        @(negedge clka);
        rsta  = 1'b0;
        n     = 0;
        vseen = 0;
        while (n < 40) begin
            @(posedge clka);
            #1;
            n++;
            if (validb !== 1'b0) vseen = 1;
            if (!init_busy) break;
        end
        wea = '0;
        enb = 1'b0;
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL sweep_len got=%0d want=16", n);
        end
        checks++;
        if (vseen != 0) begin
            failures++;
            $display("FAIL sweep_validb got=1 want=0");
        end
        do_read(4'd2, q, v);
        checks++;
        if (q !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL blocked_write got=%h/%b want=%h/1", q, v, 32'h0);
        end
        do_read(4'd5, q, v);
        checks++;
        if (q !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL preload_cleared got=%h/%b want=%h/1", q, v, 32'h0);
        end
    endtask

    task automatic test_byte_lanes;
        logic [DW-1:0] q;
        logic v;
        do_write(4'd3, 32'h1122_3344, 4'hF);
        do_write(4'd3, 32'hAABB_CCDD, 4'b0101);
        do_read(4'd3, q, v);
        checks++;
        if (q !== 32'h11BB_33DD || v !== 1'b1) begin
            failures++;
            $display("FAIL byte_lanes got=%h/%b want=%h/1", q, v, 32'h11BB_33DD);
        end
        @(posedge clka);
        #1;
        checks++;
        if (doutb !== 32'h11BB_33DD || validb !== 1'b0) begin
            failures++;
            $display("FAIL read_hold got=%h/%b want=%h/0", doutb, validb, 32'h11BB_33DD);
        end
    endtask

    task automatic test_collision;
        logic [DW-1:0] q;
        logic v;
        logic [DW-1:0] exp_coll;
`ifdef BRAM_BYPASS_EN
        exp_coll = 32'h0000_BEEF;
`else
        exp_coll = 32'h0000_0000;
`endif
        addra = 4'd7;
        dina  = 32'hDEAD_BEEF;
        wea   = 4'b0011;
        enb   = 1'b1;
        addrb = 4'd7;
        @(posedge clka);
        #1;
        wea = '0;
        enb = 1'b0;
        checks++;
        if (doutb !== exp_coll || validb !== 1'b1) begin
            failures++;
            $display("FAIL collision got=%h/%b want=%h/1", doutb, validb, exp_coll);
        end
        do_read(4'd7, q, v);
        checks++;
        if (q !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL after_collision got=%h want=%h", q, 32'h0000_BEEF);
        end
        addra = 4'd8;
        dina  = 32'hCAFE_F00D;
        wea   = 4'hF;
        enb   = 1'b1;
        addrb = 4'd3;
        @(posedge clka);
        #1;
        wea = '0;
        enb = 1'b0;
        checks++;
        if (doutb !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL no_collision got=%h want=%h", doutb, 32'h11BB_33DD);
        end
        do_read(4'd8, q, v);
        checks++;
        if (q !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL independent_write got=%h want=%h", q, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            do_write(AW'(i), DW'(i * 3), 4'hF);
        end
        enb   = 1'b1;
        addrb = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clka);
            #1;
            checks++;
            if (validb !== 1'b1 || doutb !== DW'(i * 3)) begin
                failures++;
                $display("FAIL stream_%0d got=%h/%b want=%h/1", i, doutb, validb, DW'(i * 3));
            end
            addrb = AW'(i + 1);
        end
        enb = 1'b0;
        @(posedge clka);
        #1;
        checks++;
        if (validb !== 1'b0 || doutb !== 32'd45) begin
            failures++;
            $display("FAIL stream_end got=%h/%b want=%h/0", doutb, validb, 32'd45);
        end
    endtask

    task automatic test_mid_sweep_reset;
        int n;
        logic [DW-1:0] q;
        logic v;
        @(negedge clka);
        rsta = 1'b1;
        #1;
        checks++;
        if (doutb !== 32'h0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got=%h/%b want=%h/1", doutb, init_busy, 32'h0);
        end
        @(negedge clka);
        rsta = 1'b0;
        enb  = 1'b1;
        addrb = 4'd9;
        repeat (9) @(posedge clka);
        @(negedge clka);
        rsta = 1'b1;
        repeat (2) @(posedge clka);
        #1;
        checks++;
        if (doutb !== 32'h0 || validb !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b/%b want=%h/0/1", doutb, validb, init_busy, 32'h0);
        end
        enb = 1'b0;
        @(negedge clka);
        rsta = 1'b0;
        count_busy(n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL restart_len got=%0d want=16", n);
        end
        do_read(4'd3, q, v);
        checks++;
        if (q !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL refill_low got=%h/%b want=%h/1", q, v, 32'h0);
        end
        do_read(4'd15, q, v);
        checks++;
        if (q !== 32'h0 || v !== 1'b1) begin
            failures++;
            $display("FAIL refill_high got=%h/%b want=%h/1", q, v, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_blocked_sweep();
        test_byte_lanes();
        test_collision();
        test_back_to_back();
        test_mid_sweep_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_ram_sdp.md
# block_ram_sdp

Parametrised simple-dual-port block RAM with per-byte write enables, a registered read port with a valid strobe, and a hardware zero-fill sequencer that runs after every reset. It replaces the fixed 32-bit instruction/data RAM behind the AHB memory bridges. Port A writes and port B reads share one clock. Read-during-write collision behaviour is selected at compile time.

## Interface
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_LANES = DATA_WIDTH/BYTE_WIDTH
- clka  in  1  clock; all logic is rising-edge
- rsta  in  1  reset; asynchronous, active-high
- addra  in  ADDR_WIDTH  write word address
- dina  in  DATA_WIDTH  write data
- wea  in  NUM_LANES  per-lane write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH]
- enb  in  1  read request
- addrb  in  ADDR_WIDTH  read word address
- doutb  out  DATA_WIDTH  registered read data; holds between reads
- validb  out  1  one-cycle pulse marking new doutb
- init_busy  out  1  high while the zero-fill sweep runs; port A and port B are blocked

## Operation
- Two states: CLEAR and READY. rsta forces CLEAR, clear counter = 0, doutb = 0, validb = 0, init_busy = 1. Memory array is not reset directly.
- CLEAR: each cycle writes all-zero to mem[counter] and increments the counter.
  - At counter = 2**ADDR_WIDTH-1 the write happens, then the state goes to READY and init_busy falls on the same edge.
  - In CLEAR, wea is ignored and the write is dropped, not queued. enb is ignored: validb stays 0 and doutb holds.
- READY: for each lane i with wea[i]=1, mem[addra] lane i <= dina lane i. Other lanes keep their value. wea all-zero means no write.
- READY read: enb=1 causes doutb <= mem[addrb] and validb <= 1. enb=0 causes validb <= 0 and doutb holds.
- Collision (READY, enb=1, addrb==addra, any wea bit set): the outcome depends on the configuration macro. Non-colliding addresses never interact.
- rsta asserted mid-sweep or mid-operation: the sweep restarts from address 0, and any write or read on that edge is discarded.
- Width rules: the counter is ADDR_WIDTH+1 bits wide to avoid wrap ambiguity. Addresses are word addresses with no byte-offset bits.

## Timing
- Write latency: the data is in the array at the sampling edge. A read of the same address issued on a later cycle returns it.
- Read latency: addrb/enb are sampled at edge k. doutb and validb are valid after edge k, for one cycle for validb. Back-to-back reads give one word per cycle.
- Sweep duration: init_busy is high for exactly 2**ADDR_WIDTH cycles after rsta deasserts, counted from the first rising edge with rsta low.
- There is no combinational path from inputs to outputs.

## Configuration
- BRAM_BYPASS_EN defined: write-first per lane. On a collision, doutb lanes with wea[i]=1 carry dina lane i, and the other lanes carry the stored word.
- BRAM_BYPASS_EN undefined: read-first. On a collision, doutb carries the pre-write contents in all lanes, and the array holds the new data from that edge on.
- Memory inference must stay block-RAM friendly in both modes. Bypass is a registered mux after the array read.

## Structure
- Package block_ram_pkg holds:
  - the state typedef (CLEAR, READY);
  - a lane-count function NUM_LANES(DATA_WIDTH, BYTE_WIDTH);
  - an elaboration check that DATA_WIDTH % BYTE_WIDTH == 0.
- Sub-module block_ram_clear_ctrl holds the CLEAR/READY state, the sweep counter and init_busy. It drives the internal write mux select, write address and zero data.
- The top level holds the array, the lane-write loop, the read register, validb and the bypass mux.

## Test plan
- Bench config: ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_WIDTH=8.
- Reset release: preload mem[5]=32'hFFFF_FFFF by backdoor before reset, then release rsta. Required: init_busy high for exactly 16 cycles. After that, a read of addr 5 gives doutb=0 and validb=1 one cycle later.
- Byte lanes: write addr 3 with dina=32'h1122_3344, wea=4'hF. Then write dina=32'hAABB_CCDD, wea=4'b0101. Reading addr 3 gives 32'h11BB_33DD.
- Collision: addr 7 holds 32'h0; write 32'hDEAD_BEEF with wea=4'b0011 and read addr 7 on the same edge. Required doutb: 32'h0000_BEEF with BRAM_BYPASS_EN, 32'h0 without. A following read gives 32'h0000_BEEF in both modes.
- Blocked during sweep: wea=4'hF to addr 2 with dina=32'h5A5A_5A5A and enb=1 during CLEAR. Required: validb stays 0, and a post-sweep read of addr 2 gives 0.
- Mid-sweep reset: assert rsta at sweep cycle 9 for 2 cycles. Required: doutb=0, validb=0, and init_busy high for 16 full cycles after release.
- Streaming: enb=1 on addresses 0..15 consecutively after writing addr*3. Required: validb high 16 consecutive cycles with doutb = 0,3,6,…,45.
